instr_skid_reg: RTL
===================

// Module: instr_skid_reg
// PURPOSE
//  Parametrised IF/ID instruction register. Latches fetched instruction word + PC and exposes decoded op/func fields.
//  Adds a valid/ready handshake on both sides, a 2-entry skid buffer so upstream ready is fully registered, and a
//  synchronous flush that inserts a NOP bubble. Counts consumer stall cycles. Sits between fetch and decode/CU.
// PARAMETERS
//  INSTR_W   32        instruction word width
//  PC_W      32        program counter width
//  OP_W      6         opcode field width
//  OP_LSB    26        opcode field LSB within instr
//  FUNC_W    6         func field width
//  FUNC_LSB  0         func field LSB within instr
//  NOP_INSTR 32'h0     word presented on reset/flush (INSTR_W bits)
//  CNT_W     16        stall counter width
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  flush      in   1        sync flush, discard all held entries
//  in_valid   in   1        upstream word valid
//  in_ready   out  1        block can accept (registered)
//  in_instr   in   INSTR_W  fetched instruction
//  in_pc      in   PC_W     PC of fetched instruction
//  out_valid  out  1        out_* holds a live instruction
//  out_ready  in   1        downstream consumes when out_valid
//  out_instr  out  INSTR_W  held instruction
//  out_pc     out  PC_W     held PC
//  out_op     out  OP_W     out_instr[OP_LSB +: OP_W]
//  out_func   out  FUNC_W   out_instr[FUNC_LSB +: FUNC_W]
//  stall_cnt  out  CNT_W    saturating count of out_valid & !out_ready cycles
// BEHAVIOUR
//  Reset (rst=0, async, any time incl. mid-transfer): main/skid valid=0, out_valid=0, in_ready=1,
//   out_instr=NOP_INSTR, out_pc=0, out_op/out_func=NOP fields, stall_cnt=0. Skid data regs reset to 0.
//  accept = in_valid & in_ready; drain = out_valid & out_ready (one transfer per handshake, per cycle).
//  Storage: main (drives out_*), skid (overflow). in_ready = !skid_valid, a register output (no comb path from out_ready).
//  Per-edge update, flush=0:
//   - main empty or drain: main <= skid if skid_valid (skid_valid<=0), else main <= input if accept, else main_valid<=0.
//   - main full, no drain, accept: skid <= input, skid_valid<=1 (in_ready drops next cycle).
//   - skid_valid & drain & accept: main <= skid, skid <= input (skid stays full).
//   - Order strictly preserved: skid always older than any new input.
//  States (main_valid,skid_valid): EMPTY(0,0) -> ONE(1,0) on accept; ONE -> FULL(1,1) on accept & !drain;
//   ONE -> EMPTY on drain & !accept; FULL -> ONE on drain & !accept; (0,1) unreachable.
//  Latency: input accepted at edge N appears on out_* after edge N (1 cycle) when EMPTY or draining; throughput 1/clk.
//  out_instr/out_pc hold last value when out_valid=0 after drain (not cleared); consumers qualify with out_valid.
//  flush=1 (highest priority over accept/drain): next edge main_valid=skid_valid=0, out_instr=NOP_INSTR, out_pc unchanged,
//   in_ready=1; same-cycle input word discarded even if in_valid&in_ready; a same-cycle drain still counts downstream.
//  stall_cnt: +1 per cycle with out_valid & !out_ready, saturates at 2^CNT_W-1, never wraps; unaffected by flush.
//  out_op/out_func are pure slices of out_instr (no extra latency).
// TESTING
//  1 Reset: rst=0 mid-stream -> immediately out_valid=0,in_ready=1,out_instr=NOP_INSTR,stall_cnt=0.
//  2 Stream: in_valid=1 w/ 0x2108_0020,0x0000_0022,... out_ready=1 -> each on out_* 1 clk later, op=0x08/0x00, func=0x20/0x22, no gaps.
//  3 Backpressure: out_ready=0, push A,B,C -> A,B held, in_ready=0 from cycle after B, C held upstream; out_ready=1 -> A,B,C in order.
//  4 Flush while FULL, in_valid=1 w/ D -> out_valid=0,out_instr=NOP_INSTR,in_ready=1; D never appears.
//  5 Stall count CNT_W=4: hold out_valid w/ out_ready=0 for 20 clks -> stall_cnt saturates at 15.
//  6 Simultaneous accept+drain in FULL -> skid->main, new word->skid, in_ready stays 0, order kept.

Source files
------------

// File: rtl/instr_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_skid_reg_if
// Brief    : Fetch-side / decode-side handshake bundle for instr_skid_reg.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_skid_reg_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int OP_W    = 6,
  parameter int FUNC_W  = 6,
  parameter int CNT_W   = 16
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [OP_W-1:0]    out_op;
  logic [FUNC_W-1:0]  out_func;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_op, out_func, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_op, out_func, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/instr_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : instr_skid_reg
// Brief    : IF/ID instruction register with 2-entry skid buffer, flush to NOP
//            and saturating consumer-stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_skid_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter int                 OP_W      = 6,
  parameter int                 OP_LSB    = 26,
  parameter int                 FUNC_W    = 6,
  parameter int                 FUNC_LSB  = 0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input wire logic            clk,
  input wire logic            rst,
  instr_skid_reg_if.slave     bus
);
  localparam logic [CNT_W-1:0] c_cntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Encoding is {skid_valid, main_valid}, so in_ready is a raw flop bit.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [INSTR_W-1:0] r_mainInstr;
  logic [PC_W-1:0]    r_mainPc;
  logic [INSTR_W-1:0] r_skidInstr;
  logic [PC_W-1:0]    r_skidPc;
  logic [CNT_W-1:0]   r_stallCnt;

  logic w_mainValid;
  logic w_inReady;
  logic w_accept;
  logic w_drain;
  logic w_mainFromSkid;
  logic w_mainFromIn;
  logic w_skidFromIn;

  assign w_mainValid = r_state[0];
  assign w_inReady   = ~r_state[1];
  assign w_accept    = bus.in_valid & w_inReady;
  assign w_drain     = w_mainValid & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_mainFromSkid = 1'b0;
    w_mainFromIn   = 1'b0;
    w_skidFromIn   = 1'b0;
    if (bus.flush) begin
      w_stateNext = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_mainFromIn = 1'b1;
            w_stateNext  = S_ONE;
          end
        end
        S_ONE: begin
          if (w_drain) begin
            w_mainFromIn = w_accept;
            w_stateNext  = w_accept ? S_ONE : S_EMPTY;
          end else if (w_accept) begin
            w_skidFromIn = 1'b1;
            w_stateNext  = S_FULL;
          end
        end
        S_FULL: begin
          // Skid is always older than any new word, so it moves up first.
          if (w_drain) begin
            w_mainFromSkid = 1'b1;
            w_skidFromIn   = w_accept;
            w_stateNext    = w_accept ? S_FULL : S_ONE;
          end
        end
        default: w_stateNext = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mainInstr <= NOP_INSTR;
      r_mainPc    <= '0;
      r_skidInstr <= '0;
      r_skidPc    <= '0;
    end else begin
      // Flush bubbles the instruction word only; PC keeps its last value.
      if (bus.flush) begin
        r_mainInstr <= NOP_INSTR;
      end else if (w_mainFromSkid) begin
        r_mainInstr <= r_skidInstr;
        r_mainPc    <= r_skidPc;
      end else if (w_mainFromIn) begin
        r_mainInstr <= bus.in_instr;
        r_mainPc    <= bus.in_pc;
      end
      if (!bus.flush && w_skidFromIn) begin
        r_skidInstr <= bus.in_instr;
        r_skidPc    <= bus.in_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCnt <= '0;
    end else if (w_mainValid && !bus.out_ready && (r_stallCnt != c_cntMax)) begin
      r_stallCnt <= r_stallCnt + c_cntOne;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_mainValid;
  assign bus.out_instr = r_mainInstr;
  assign bus.out_pc    = r_mainPc;
  assign bus.out_op    = r_mainInstr[OP_LSB +: OP_W];
  assign bus.out_func  = r_mainInstr[FUNC_LSB +: FUNC_W];
  assign bus.stall_cnt = r_stallCnt;
endmodule
`default_nettype wire
